// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one async FIFO write port among NUM_REQ
// producers, granting bounded bursts and stalling (not releasing) on full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] owner_nxt, rr_ptr, rr_ptr_nxt, owner_inc, pick;
  logic             pick_valid;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             req_owner;
  logic             last_write;

  assign req_owner  = req[owner];
  assign busy       = (state == BURST);
  assign wr_en      = busy & req_owner & ~full;
  assign data_in    = wr_en ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign owner_inc  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign last_write = wr_en && ((burst_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST));

  always_comb begin
    ack = '0;
    if (wr_en) ack[owner] = 1'b1;
  end

  // Rotating priority search: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    logic [SUM_W-1:0] sum;
    pick       = '0;
    pick_valid = 1'b0;
    sum        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      if (!pick_valid && req[sum[PTR_W-1:0]]) begin
        pick_valid = 1'b1;
        pick       = sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        // A dropped request releases even under full; full alone only stalls.
        if (!req_owner) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
        end else if (wr_en) begin
          burst_cnt_nxt = burst_cnt + CNT_W'(1);
          if (last_write) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = owner_inc;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester k presents {k+1, word count} and
// advances on ack; each step checks every output against hand-computed values.
module tb_fifo_wr_arbiter;

  logic        clk_wr;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        full;
  logic        wr_en;
  logic [7:0]  data_in;
  logic [1:0]  owner;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [3:0] word_cnt [4] = '{4'd0, 4'd0, 4'd0, 4'd0};

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk_wr   (clk_wr),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .full     (full),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .owner    (owner),
    .busy     (busy)
  );

  initial begin
    clk_wr = 1'b0;
    forever #5 clk_wr = ~clk_wr;
  end

  // Requester k only advances its word when its ack was seen at the edge.
  always @(posedge clk_wr) begin
    for (int k = 0; k < 4; k++)
      if (ack[k]) word_cnt[k] <= word_cnt[k] + 4'd1;
  end

  always_comb begin
    req_data = '0;
    for (int k = 0; k < 4; k++)
      req_data[k*8 +: 8] = {4'(k + 1), word_cnt[k]};
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic exp_wr, input logic [3:0] exp_ack,
                              input logic [7:0] exp_data, input logic [1:0] exp_owner,
                              input logic exp_busy);
    compare({tag, " wr_en"},   32'(wr_en),   32'(exp_wr));
    compare({tag, " ack"},     32'(ack),     32'(exp_ack));
    compare({tag, " data_in"}, 32'(data_in), 32'(exp_data));
    compare({tag, " owner"},   32'(owner),   32'(exp_owner));
    compare({tag, " busy"},    32'(busy),    32'(exp_busy));
  endtask

  task automatic expect_idle(input string tag, input logic [1:0] own);
    check_output(tag, 1'b0, 4'b0000, 8'h00, own, 1'b0);
  endtask

  task automatic expect_hold(input string tag, input logic [1:0] own);
    check_output(tag, 1'b0, 4'b0000, 8'h00, own, 1'b1);
  endtask

  task automatic expect_write(input string tag, input logic [1:0] own, input logic [7:0] data);
    check_output(tag, 1'b1, 4'b0001 << own, data, own, 1'b1);
  endtask

  task automatic apply_stimulus(input logic [3:0] r, input logic f);
    @(posedge clk_wr);
    #1;
    req  = r;
    full = f;
    #3;
  endtask

  initial begin
    logic [1:0] own;
    logic [7:0] start [4];
    start = '{8'h20, 8'h30, 8'h40, 8'h18};
    rst_n = 1'b0;
    req   = '0;
    full  = 1'b0;
    #12;
    expect_idle("reset", 2'd0);
    rst_n = 1'b1;

    $display("[TB] single requester");
    apply_stimulus(4'b0001, 1'b0); expect_idle("t1 idle0", 2'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'b0001, 1'b0); expect_write($sformatf("t1 a w%0d", i), 2'd0, 8'h10 + 8'(i));
    end
    apply_stimulus(4'b0001, 1'b0); expect_idle("t1 gap", 2'd0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'b0001, 1'b0); expect_write($sformatf("t1 b w%0d", i), 2'd0, 8'h14 + 8'(i));
    end
    apply_stimulus(4'b0000, 1'b0); expect_idle("t1 end", 2'd0);

    $display("[TB] all requesting");
    apply_stimulus(4'b1111, 1'b0); expect_idle("t2 idle0", 2'd0);
    for (int b = 0; b < 4; b++) begin
      own = 2'(b + 1);
      for (int i = 0; i < 4; i++) begin
        apply_stimulus(4'b1111, 1'b0);
        expect_write($sformatf("t2 b%0d w%0d", b, i), own, start[b] + 8'(i));
      end
      if (b < 3) begin
        apply_stimulus(4'b1111, 1'b0); expect_idle($sformatf("t2 gap%0d", b), own);
      end
    end

    $display("[TB] back-pressure");
    apply_stimulus(4'b0100, 1'b0); expect_idle("t3 idle", 2'd0);
    apply_stimulus(4'b0100, 1'b0); expect_write("t3 w0", 2'd2, 8'h34);
    apply_stimulus(4'b0100, 1'b0); expect_write("t3 w1", 2'd2, 8'h35);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(4'b0100, 1'b1); expect_hold($sformatf("t3 stall%0d", i), 2'd2);
    end
    apply_stimulus(4'b0100, 1'b0); expect_write("t3 w2", 2'd2, 8'h36);
    apply_stimulus(4'b0100, 1'b0); expect_write("t3 w3", 2'd2, 8'h37);
    apply_stimulus(4'b0000, 1'b0); expect_idle("t3 end", 2'd2);

    $display("[TB] early release");
    apply_stimulus(4'b0010, 1'b0); expect_idle("t4 idle", 2'd2);
    apply_stimulus(4'b1010, 1'b0); expect_write("t4 w0", 2'd1, 8'h24);
    apply_stimulus(4'b1010, 1'b0); expect_write("t4 w1", 2'd1, 8'h25);
    apply_stimulus(4'b1000, 1'b0); expect_hold("t4 drop", 2'd1);
    apply_stimulus(4'b1001, 1'b0); expect_idle("t4 idle2", 2'd1);
    apply_stimulus(4'b1000, 1'b0); expect_write("t4 r3 w0", 2'd3, 8'h44);
    apply_stimulus(4'b0000, 1'b0); expect_hold("t4 r3 drop", 2'd3);
    apply_stimulus(4'b0000, 1'b0); expect_idle("t4 end", 2'd3);

    $display("[TB] wrap-around");
    apply_stimulus(4'b0100, 1'b0); expect_idle("t5 setup", 2'd3);
    apply_stimulus(4'b0000, 1'b0); expect_hold("t5 setup drop", 2'd2);
    apply_stimulus(4'b1001, 1'b0); expect_idle("t5 idle0", 2'd2);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'b1001, 1'b0); expect_write($sformatf("t5 r3 w%0d", i), 2'd3, 8'h45 + 8'(i));
    end
    apply_stimulus(4'b1001, 1'b0); expect_idle("t5 idle1", 2'd3);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(4'b1001, 1'b0); expect_write($sformatf("t5 r0 w%0d", i), 2'd0, 8'h1c + 8'(i));
    end
    apply_stimulus(4'b0000, 1'b0); expect_idle("t5 end", 2'd0);

    $display("[TB] async reset mid-burst");
    apply_stimulus(4'b0010, 1'b0); expect_idle("t6 idle", 2'd0);
    apply_stimulus(4'b0010, 1'b0); expect_write("t6 w0", 2'd1, 8'h26);
    apply_stimulus(4'b0010, 1'b0); expect_write("t6 w1", 2'd1, 8'h27);
    apply_stimulus(4'b0010, 1'b0); expect_write("t6 w2", 2'd1, 8'h28);
    #1 rst_n = 1'b0;
    #1 expect_idle("t6 in reset", 2'd0);
    @(posedge clk_wr);
    #2 rst_n = 1'b1;
    #1 expect_idle("t6 released", 2'd0);
    apply_stimulus(4'b0010, 1'b0); expect_write("t6 replay", 2'd1, 8'h28);
    apply_stimulus(4'b0000, 1'b0); expect_hold("t6 drop", 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
